// File: rtl/e_mdu.sv
// Multi-cycle multiply/divide unit for the Execute stage.
// Computes mult/multu/div/divu into pending registers at launch and commits to HI/LO after a fixed latency.
module e_mdu #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] SrcA,
  input  logic [31:0] SrcB,
  input  logic [3:0]  MDUOp,
  input  logic        Start,
  output logic        Busy,
  output logic [31:0] HI,
  output logic [31:0] LO,
  output logic [31:0] MDUResult
);

  localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CW         = $clog2(MAX_CYCLES + 1);

  typedef enum logic [3:0] {
    OP_NONE  = 4'd0,
    OP_MULT  = 4'd1,
    OP_MULTU = 4'd2,
    OP_DIV   = 4'd3,
    OP_DIVU  = 4'd4,
    OP_MFHI  = 4'd5,
    OP_MFLO  = 4'd6,
    OP_MTHI  = 4'd7,
    OP_MTLO  = 4'd8
  } op_e;

  typedef enum logic {S_IDLE, S_RUN} state_e;

  state_e        state_q, state_d;
  logic [CW-1:0] count_q;
  logic [31:0]   p_hi, p_lo;
  logic          p_wr;

  logic        launch, commit, is_mult;
  logic        neg_a, neg_b;
  logic [31:0] mag_a, mag_b, quo, rem;
  logic [63:0] prod;
  logic [31:0] res_hi, res_lo;
  logic        res_wr;

  assign launch  = (state_q == S_IDLE) && Start && (MDUOp >= OP_MULT) && (MDUOp <= OP_DIVU);
  assign commit  = (state_q == S_RUN) && (count_q == CW'(1));
  assign is_mult = (MDUOp == OP_MULT) || (MDUOp == OP_MULTU);
  assign Busy    = (state_q == S_RUN);

  // Division works on magnitudes so the 0x80000000 / -1 case wraps naturally.
  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    neg_a  = 1'b0;
    neg_b  = 1'b0;
    mag_a  = SrcA;
    mag_b  = SrcB;
    quo    = '0;
    rem    = '0;
    prod   = '0;
    res_hi = '0;
    res_lo = '0;
    res_wr = 1'b0;

    // Sign-extending to 64 bits makes one unsigned multiplier serve both mult and multu.
    prod = {{32{(MDUOp == OP_MULT) & SrcA[31]}}, SrcA} *
           {{32{(MDUOp == OP_MULT) & SrcB[31]}}, SrcB};

    neg_a = (MDUOp == OP_DIV) & SrcA[31];
    neg_b = (MDUOp == OP_DIV) & SrcB[31];
    mag_a = neg_a ? -SrcA : SrcA;
    mag_b = neg_b ? -SrcB : SrcB;
    if (mag_b != '0) begin
      quo = mag_a / mag_b;
      rem = mag_a % mag_b;
    end

    if (is_mult) begin
      res_hi = prod[63:32];
      res_lo = prod[31:0];
      res_wr = 1'b1;
    end else begin
      res_hi = neg_a ? -rem : rem;
      res_lo = (neg_a ^ neg_b) ? -quo : quo;
      res_wr = (SrcB != '0);
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (launch) state_d = S_RUN;
      S_RUN:   if (commit) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count_q <= '0;
      p_hi    <= '0;
      p_lo    <= '0;
      p_wr    <= 1'b0;
      HI      <= '0;
      LO      <= '0;
    end else if (launch) begin
      count_q <= is_mult ? CW'(MULT_CYCLES) : CW'(DIV_CYCLES);
      p_hi    <= res_hi;
      p_lo    <= res_lo;
      p_wr    <= res_wr;
    end else if (state_q == S_RUN) begin
      count_q <= count_q - CW'(1);
      if (commit && p_wr) begin
        HI <= p_hi;
        LO <= p_lo;
      end
    end else if (!Start) begin
      if (MDUOp == OP_MTHI) HI <= SrcA;
      if (MDUOp == OP_MTLO) LO <= SrcA;
    end
  end

  always_comb begin
    case (MDUOp)
      OP_MFHI: MDUResult = HI;
      OP_MFLO: MDUResult = LO;
      default: MDUResult = '0;
    endcase
  end

endmodule

// File: tb/tb_e_mdu.sv
// Self-checking bench for e_mdu: a reference model pushes expected {HI,LO} at launch,
// and each commit pops and compares; Busy length and HI/LO hold are checked every cycle.
module tb_e_mdu;

  logic        clk;
  logic        reset;
  logic [31:0] SrcA, SrcB;
  logic [3:0]  MDUOp;
  logic        Start;
  logic        Busy;
  logic [31:0] HI, LO, MDUResult;

  int checks = 0;
  int errors = 0;

  logic [63:0] exp_q[$];
  logic [31:0] m_hi, m_lo;

  e_mdu #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
    .clk(clk), .reset(reset), .SrcA(SrcA), .SrcB(SrcB), .MDUOp(MDUOp),
    .Start(Start), .Busy(Busy), .HI(HI), .LO(LO), .MDUResult(MDUResult)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference result {HI,LO}; divide by zero keeps the current values.
  function automatic logic [63:0] model(input logic [3:0] op, input logic [31:0] a, b,
                                        input logic [31:0] hi, lo);
    longint sa, sb, sq, sr;
    logic [63:0] r;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    r  = {hi, lo};
    case (op)
      4'd1: r = 64'(sa * sb);
      4'd2: r = {32'd0, a} * {32'd0, b};
      4'd3: if (b != 0) begin
        sq = sa / sb;
        sr = sa % sb;
        r  = {sr[31:0], sq[31:0]};
      end
      4'd4: if (b != 0) r = {a % b, a / b};
      default: r = {hi, lo};
    endcase
    return r;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [3:0] op, input logic [31:0] a, b);
    exp_q.push_back(model(op, a, b, m_hi, m_lo));
    MDUOp = op; SrcA = a; SrcB = b; Start = 1'b1;
    step();
    Start = 1'b0; MDUOp = 4'd0;
  endtask

  // Called right after issue(): counts Busy cycles, checks HI/LO hold, then pops the commit.
  task automatic wait_done(input int n_exp, input string name);
    int n;
    logic [63:0] e;
    n = 0;
    while (Busy === 1'b1 && n < 100) begin
      checks++;
      if (HI !== m_hi || LO !== m_lo) begin
        errors++;
        $display("FAIL %s hold cyc %0d: got HI=%h LO=%h expected HI=%h LO=%h", name, n, HI, LO, m_hi, m_lo);
      end
      n++;
      step();
    end
    checks++;
    if (n != n_exp) begin
      errors++;
      $display("FAIL %s busy_len: got %0d expected %0d", name, n, n_exp);
    end
    if (exp_q.size() == 0) begin
      errors++;
      $display("FAIL %s scoreboard: got empty queue expected an entry", name);
    end else begin
      e = exp_q.pop_front();
      checks++;
      if ({HI, LO} !== e) begin
        errors++;
        $display("FAIL %s result: got HI=%h LO=%h expected HI=%h LO=%h", name, HI, LO, e[63:32], e[31:0]);
      end
      m_hi = e[63:32];
      m_lo = e[31:0];
    end
  endtask

  task automatic expect32(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, got, want);
    end
  endtask

  task automatic test_reset();
    reset = 1'b0; Start = 1'b0; MDUOp = 4'd0; SrcA = '0; SrcB = '0;
    m_hi = '0; m_lo = '0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
    step();
    expect32("reset_hi", HI, 32'h0);
    expect32("reset_lo", LO, 32'h0);
    expect32("reset_busy", {31'd0, Busy}, 32'h0);
    MDUOp = 4'd5; #1;
    expect32("reset_mfhi", MDUResult, 32'h0);
    MDUOp = 4'd0;
  endtask

  task automatic test_mult();
    issue(4'd1, 32'hFFFF_FFFB, 32'd3);
    wait_done(5, "mult");
    expect32("mult_hi", HI, 32'hFFFF_FFFF);
    expect32("mult_lo", LO, 32'hFFFF_FFF1);
    issue(4'd2, 32'hFFFF_FFFF, 32'd2);
    wait_done(5, "multu");
    expect32("multu_hi", HI, 32'h0000_0001);
    expect32("multu_lo", LO, 32'hFFFF_FFFE);
  endtask

  task automatic test_div();
    issue(4'd3, 32'hFFFF_FFF9, 32'd2);
    wait_done(10, "div");
    expect32("div_lo", LO, 32'hFFFF_FFFD);
    expect32("div_hi", HI, 32'hFFFF_FFFF);
    issue(4'd4, 32'd7, 32'd0);
    wait_done(10, "divu_by_zero");
    expect32("divz_hi", HI, 32'hFFFF_FFFF);
    issue(4'd3, 32'h8000_0000, 32'hFFFF_FFFF);
    wait_done(10, "div_overflow");
    expect32("divov_lo", LO, 32'h8000_0000);
    expect32("divov_hi", HI, 32'h0);
    issue(4'd4, 32'hF000_0001, 32'd7);
    wait_done(10, "divu");
    issue(4'd3, 32'd1000, 32'hFFFF_FFF9);
    wait_done(10, "div_neg_divisor");
  endtask

  task automatic test_ignored();
    int n;
    logic [63:0] e;
    issue(4'd3, 32'hFFFF_FC18, 32'd7);
    n = 1;
    while (Busy === 1'b1 && n < 100) begin
      checks++;
      if (HI !== m_hi || LO !== m_lo) begin
        errors++;
        $display("FAIL ignore hold cyc %0d: got HI=%h LO=%h expected HI=%h LO=%h", n, HI, LO, m_hi, m_lo);
      end
      if (n == 3) begin
        MDUOp = 4'd1; SrcA = 32'd9; SrcB = 32'd9; Start = 1'b1;
      end else if (n == 4) begin
        MDUOp = 4'd7; SrcA = 32'h1234; Start = 1'b0;
      end else begin
        MDUOp = 4'd0; Start = 1'b0;
      end
      step();
      n++;
    end
    MDUOp = 4'd0; Start = 1'b0;
    checks++;
    if (n != 11) begin
      errors++;
      $display("FAIL ignore busy_len: got %0d expected 10", n - 1);
    end
    e = exp_q.pop_front();
    checks++;
    if ({HI, LO} !== e) begin
      errors++;
      $display("FAIL ignore result: got HI=%h LO=%h expected HI=%h LO=%h", HI, LO, e[63:32], e[31:0]);
    end
    m_hi = e[63:32]; m_lo = e[31:0];

    // Start with mthi/mtlo or an out-of-range code has no effect.
    MDUOp = 4'd7; SrcA = 32'hDEAD_BEEF; Start = 1'b1;
    step();
    expect32("start_mthi_busy", {31'd0, Busy}, 32'h0);
    expect32("start_mthi_hi", HI, m_hi);
    MDUOp = 4'd9; Start = 1'b1;
    step();
    Start = 1'b0;
    expect32("start_op9_busy", {31'd0, Busy}, 32'h0);

    MDUOp = 4'd7; SrcA = 32'h1234;
    step();
    MDUOp = 4'd8; SrcA = 32'h5678_9ABC;
    step();
    m_hi = 32'h1234; m_lo = 32'h5678_9ABC;
    MDUOp = 4'd5; #1;
    expect32("mfhi_after_mthi", MDUResult, 32'h0000_1234);
    MDUOp = 4'd6; #1;
    expect32("mflo_after_mtlo", MDUResult, 32'h5678_9ABC);
    MDUOp = 4'd2; #1;
    expect32("mduresult_other_op", MDUResult, 32'h0);
    MDUOp = 4'd0;
  endtask

  task automatic test_back_to_back();
    issue(4'd1, 32'h7FFF_FFFF, 32'h7FFF_FFFF);
    wait_done(5, "b2b_mult");
    issue(4'd2, 32'h8000_0000, 32'h8000_0000);
    wait_done(5, "b2b_multu");
    issue(4'd1, 32'h8000_0000, 32'h8000_0000);
    wait_done(5, "b2b_mult_minmin");
  endtask

  task automatic test_abort();
    issue(4'd1, 32'd123, 32'd456);
    void'(exp_q.pop_back());
    step();
    #3 reset = 1'b0;
    #1;
    expect32("abort_busy", {31'd0, Busy}, 32'h0);
    expect32("abort_hi", HI, 32'h0);
    expect32("abort_lo", LO, 32'h0);
    m_hi = '0; m_lo = '0;
    step();
    reset = 1'b1;
    for (int i = 0; i < 8; i++) begin
      step();
      checks++;
      if (Busy !== 1'b0 || HI !== 32'h0 || LO !== 32'h0) begin
        errors++;
        $display("FAIL abort_no_commit cyc %0d: got Busy=%b HI=%h LO=%h expected 0 0 0", i, Busy, HI, LO);
      end
    end
  endtask

  initial begin
    test_reset();
    test_mult();
    test_div();
    test_ignored();
    test_back_to_back();
    test_abort();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
